// File: rtl/lsu_load_queue.sv
// Non-blocking load queue: store-buffer forwarding, in-order dcache request/response
// matching, load data extraction and program-order writeback to the ROB.
package global_config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned PLEN;
  } cfg_t;

  localparam cfg_t DefaultCfg = '{XLEN: 32'd32, PLEN: 32'd32};

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LD  = 3'd3,
    LSU_LBU = 3'd4,
    LSU_LHU = 3'd5,
    LSU_LWU = 3'd6
  } lsu_op_e;
endpackage

module lsu_load_queue
  import global_config_pkg::*;
#(
  parameter cfg_t        Cfg           = DefaultCfg,
  parameter int unsigned ROB_IDX_WIDTH = 6,
  parameter int unsigned LQ_DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [Cfg.PLEN-1:0]      req_addr_i,
  input  lsu_op_e                  req_op_i,
  input  logic [ROB_IDX_WIDTH-1:0] req_rob_idx_i,
  output logic [Cfg.PLEN-1:0]      sb_load_addr_o,
  input  logic                     sb_load_hit_i,
  input  logic [Cfg.XLEN-1:0]      sb_load_data_i,
  output logic                     ld_req_valid_o,
  input  logic                     ld_req_ready_i,
  output logic [Cfg.PLEN-1:0]      ld_req_addr_o,
  output lsu_op_e                  ld_req_op_o,
  input  logic                     ld_rsp_valid_i,
  output logic                     ld_rsp_ready_o,
  input  logic [Cfg.XLEN-1:0]      ld_rsp_data_i,
  input  logic                     ld_rsp_err_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [ROB_IDX_WIDTH-1:0] wb_rob_idx_o,
  output logic [Cfg.XLEN-1:0]      wb_data_o,
  output logic                     wb_exception_o,
  output logic [4:0]               wb_ecause_o
);
  localparam int unsigned XLEN = Cfg.XLEN;
  localparam int unsigned PLEN = Cfg.PLEN;
  localparam int unsigned IW   = $clog2(LQ_DEPTH);
  localparam int unsigned PW   = IW + 1;
  localparam int unsigned DW   = IW + 2;
  localparam int unsigned OFFW = $clog2(XLEN / 8);

  typedef enum logic [1:0] {FREE, WAIT_ISSUE, WAIT_RSP, DONE} lq_state_e;

  typedef struct packed {
    logic [PLEN-1:0]          addr;
    lsu_op_e                  op;
    logic [ROB_IDX_WIDTH-1:0] rob;
    logic [XLEN-1:0]          data;
    logic                     exc;
    logic [4:0]               cause;
  } entry_t;

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                              input logic [OFFW-1:0] off,
                                              input lsu_op_e         op);
    logic [63:0] s;
    logic [63:0] r;
    s = '0;
    s[XLEN-1:0] = word >> {off, 3'b000};
    case (op)
      LSU_LB:  r = {{56{s[7]}}, s[7:0]};
      LSU_LH:  r = {{48{s[15]}}, s[15:0]};
      LSU_LW:  r = {{32{s[31]}}, s[31:0]};
      LSU_LBU: r = {56'd0, s[7:0]};
      LSU_LHU: r = {48'd0, s[15:0]};
      LSU_LWU: r = {32'd0, s[31:0]};
      default: r = s;
    endcase
    return r[XLEN-1:0];
  endfunction

  function automatic logic misaligned(input logic [2:0] a, input lsu_op_e op);
    case (op)
      LSU_LH, LSU_LHU: return a[0];
      LSU_LW, LSU_LWU: return |a[1:0];
      LSU_LD:          return |a[2:0];
      default:         return 1'b0;
    endcase
  endfunction

  lq_state_e       state_q [LQ_DEPTH];
  entry_t          ent_q   [LQ_DEPTH];
  logic [PW-1:0]   alloc_q, head_q, count;
  logic [DW-1:0]   drain_q, drain_sum;
  logic [IW-1:0]   alloc_idx, head_idx, iss_idx, rsp_idx, scan_idx;
  logic [IW:0]     n_wait_rsp;
  logic            iss_found, rsp_found, full, alloc_en, issue_hs, wb_hs;
  entry_t          new_ent;
  lq_state_e       new_state;

  assign alloc_idx = alloc_q[IW-1:0];
  assign head_idx  = head_q[IW-1:0];
  assign count     = alloc_q - head_q;
  assign full      = (alloc_q[IW-1:0] == head_q[IW-1:0]) && (alloc_q[IW] != head_q[IW]);

  // Issue and response positions are the oldest WAIT_ISSUE / WAIT_RSP entries found by
  // scanning forward from head; DONE entries (forwarded, misaligned) are skipped in one go.
  always_comb begin
    iss_found  = 1'b0;
    iss_idx    = '0;
    rsp_found  = 1'b0;
    rsp_idx    = '0;
    n_wait_rsp = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < LQ_DEPTH; k++) begin
      scan_idx = head_idx + IW'(k);
      if (PW'(k) < count) begin
        if (!iss_found && state_q[scan_idx] == WAIT_ISSUE) begin
          iss_found = 1'b1;
          iss_idx   = scan_idx;
        end
        if (!rsp_found && state_q[scan_idx] == WAIT_RSP) begin
          rsp_found = 1'b1;
          rsp_idx   = scan_idx;
        end
      end
      if (state_q[IW'(k)] == WAIT_RSP) n_wait_rsp = n_wait_rsp + (IW+1)'(1);
    end
  end

  always_comb begin
    new_ent       = '0;
    new_ent.addr  = req_addr_i;
    new_ent.op    = req_op_i;
    new_ent.rob   = req_rob_idx_i;
    new_state     = WAIT_ISSUE;
    if (misaligned(req_addr_i[2:0], req_op_i)) begin
      new_state     = DONE;
      new_ent.exc   = 1'b1;
      new_ent.cause = 5'd4;
    end else if (sb_load_hit_i) begin
      new_state     = DONE;
      new_ent.data  = extract(sb_load_data_i, req_addr_i[OFFW-1:0], req_op_i);
    end
  end

  assign req_ready_o    = !full;
  assign sb_load_addr_o = req_addr_i;
  assign ld_rsp_ready_o = 1'b1;
  assign alloc_en       = req_valid_i && req_ready_o;

  // Requests are held off while drained responses are still owed, so none can be mis-attributed.
  assign ld_req_valid_o = iss_found && (drain_q == '0);
  assign ld_req_addr_o  = ld_req_valid_o ? ent_q[iss_idx].addr : '0;
  assign ld_req_op_o    = ld_req_valid_o ? ent_q[iss_idx].op : LSU_LB;
  assign issue_hs       = ld_req_valid_o && ld_req_ready_i;

  assign wb_valid_o     = (state_q[head_idx] == DONE);
  assign wb_rob_idx_o   = wb_valid_o ? ent_q[head_idx].rob : '0;
  assign wb_data_o      = wb_valid_o ? ent_q[head_idx].data : '0;
  assign wb_exception_o = wb_valid_o && ent_q[head_idx].exc;
  assign wb_ecause_o    = wb_valid_o ? ent_q[head_idx].cause : '0;
  assign wb_hs          = wb_valid_o && wb_ready_i;

  assign drain_sum = drain_q + DW'(n_wait_rsp) + DW'(issue_hs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '{default: FREE};
      ent_q   <= '{default: '0};
      alloc_q <= '0;
      head_q  <= '0;
      drain_q <= '0;
    end else if (flush_i) begin
      state_q <= '{default: FREE};
      alloc_q <= '0;
      head_q  <= '0;
      // A response arriving in the flush cycle settles one of the requests being counted.
      drain_q <= (ld_rsp_valid_i && drain_sum != '0) ? drain_sum - DW'(1) : drain_sum;
    end else begin
      if (alloc_en) begin
        ent_q[alloc_idx]   <= new_ent;
        state_q[alloc_idx] <= new_state;
        alloc_q            <= alloc_q + PW'(1);
      end
      if (issue_hs) state_q[iss_idx] <= WAIT_RSP;
      if (ld_rsp_valid_i) begin
        if (drain_q != '0) begin
          drain_q <= drain_q - DW'(1);
        end else if (rsp_found) begin
          state_q[rsp_idx]     <= DONE;
          ent_q[rsp_idx].exc   <= ld_rsp_err_i;
          ent_q[rsp_idx].cause <= ld_rsp_err_i ? 5'd5 : 5'd0;
          ent_q[rsp_idx].data  <= ld_rsp_err_i ? '0 :
            extract(ld_rsp_data_i, ent_q[rsp_idx].addr[OFFW-1:0], ent_q[rsp_idx].op);
        end
      end
      if (wb_hs) begin
        state_q[head_idx] <= FREE;
        head_q            <= head_q + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_lsu_load_queue.sv
// Directed bench for lsu_load_queue: hand-computed expectations per scenario.
module tb_lsu_load_queue;
  import global_config_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  lsu_op_e     req_op_i;
  logic [5:0]  req_rob_idx_i;
  logic [31:0] sb_load_addr_o;
  logic        sb_load_hit_i;
  logic [31:0] sb_load_data_i;
  logic        ld_req_valid_o;
  logic        ld_req_ready_i;
  logic [31:0] ld_req_addr_o;
  lsu_op_e     ld_req_op_o;
  logic        ld_rsp_valid_i;
  logic        ld_rsp_ready_o;
  logic [31:0] ld_rsp_data_i;
  logic        ld_rsp_err_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [5:0]  wb_rob_idx_o;
  logic [31:0] wb_data_o;
  logic        wb_exception_o;
  logic [4:0]  wb_ecause_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  lsu_load_queue #(.Cfg(DefaultCfg), .ROB_IDX_WIDTH(6), .LQ_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_op_i(req_op_i), .req_rob_idx_i(req_rob_idx_i),
    .sb_load_addr_o(sb_load_addr_o), .sb_load_hit_i(sb_load_hit_i), .sb_load_data_i(sb_load_data_i),
    .ld_req_valid_o(ld_req_valid_o), .ld_req_ready_i(ld_req_ready_i),
    .ld_req_addr_o(ld_req_addr_o), .ld_req_op_o(ld_req_op_o),
    .ld_rsp_valid_i(ld_rsp_valid_i), .ld_rsp_ready_o(ld_rsp_ready_o),
    .ld_rsp_data_i(ld_rsp_data_i), .ld_rsp_err_i(ld_rsp_err_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rob_idx_o(wb_rob_idx_o),
    .wb_data_o(wb_data_o), .wb_exception_o(wb_exception_o), .wb_ecause_o(wb_ecause_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input lsu_op_e op, input logic [5:0] rob,
                      input logic hit, input logic [31:0] sbd);
    req_valid_i = 1'b1; req_addr_i = a; req_op_i = op; req_rob_idx_i = rob;
    sb_load_hit_i = hit; sb_load_data_i = sbd;
    cyc();
    req_valid_i = 1'b0; req_addr_i = '0; sb_load_hit_i = 1'b0; sb_load_data_i = '0;
  endtask

  task automatic respond(input logic [31:0] d, input logic err);
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = d; ld_rsp_err_i = err;
    cyc();
    ld_rsp_valid_i = 1'b0; ld_rsp_data_i = '0; ld_rsp_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_op_i = LSU_LB;
    req_rob_idx_i = '0; sb_load_hit_i = 1'b0; sb_load_data_i = '0; ld_req_ready_i = 1'b0;
    ld_rsp_valid_i = 1'b0; ld_rsp_data_i = '0; ld_rsp_err_i = 1'b0; wb_ready_i = 1'b1;
    cyc(); cyc();
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", req_ready_o); end
    checks++; if (ld_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_ld_req_valid got=%b exp=0", ld_req_valid_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid_o); end
    checks++; if (ld_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL rst_rsp_ready got=%b exp=1", ld_rsp_ready_o); end
    checks++; if (ld_req_addr_o !== 32'h0) begin errors++; $display("FAIL rst_ld_addr got=%h exp=0", ld_req_addr_o); end
    checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL rst_wb_data got=%h exp=0", wb_data_o); end
    checks++; if (wb_rob_idx_o !== 6'd0) begin errors++; $display("FAIL rst_wb_rob got=%0d exp=0", wb_rob_idx_o); end
    checks++; if (wb_ecause_o !== 5'd0) begin errors++; $display("FAIL rst_wb_ecause got=%0d exp=0", wb_ecause_o); end
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_lw_basic();
    req_valid_i = 1'b1; req_addr_i = 32'h100; req_op_i = LSU_LW; req_rob_idx_i = 6'd5;
    #1;
    checks++; if (sb_load_addr_o !== 32'h100) begin errors++; $display("FAIL lw_sb_addr got=%h exp=100", sb_load_addr_o); end
    cyc();
    req_valid_i = 1'b0;
    checks++; if (ld_req_valid_o !== 1'b1) begin errors++; $display("FAIL lw_req_valid got=%b exp=1", ld_req_valid_o); end
    checks++; if (ld_req_addr_o !== 32'h100) begin errors++; $display("FAIL lw_req_addr got=%h exp=100", ld_req_addr_o); end
    checks++; if (ld_req_op_o !== LSU_LW) begin errors++; $display("FAIL lw_req_op got=%0d exp=%0d", ld_req_op_o, LSU_LW); end
    ld_req_ready_i = 1'b1;
    cyc();
    ld_req_ready_i = 1'b0;
    checks++; if (ld_req_valid_o !== 1'b0) begin errors++; $display("FAIL lw_req_drop got=%b exp=0", ld_req_valid_o); end
    cyc();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL lw_wb_early got=%b exp=0", wb_valid_o); end
    respond(32'h8000_00F0, 1'b0);
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL lw_wb_valid got=%b exp=1", wb_valid_o); end
    checks++; if (wb_data_o !== 32'h8000_00F0) begin errors++; $display("FAIL lw_wb_data got=%h exp=800000f0", wb_data_o); end
    checks++; if (wb_rob_idx_o !== 6'd5) begin errors++; $display("FAIL lw_wb_rob got=%0d exp=5", wb_rob_idx_o); end
    checks++; if (wb_exception_o !== 1'b0) begin errors++; $display("FAIL lw_wb_exc got=%b exp=0", wb_exception_o); end
    cyc();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL lw_wb_retired got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_byte_ext();
    push(32'h103, LSU_LB, 6'd1, 1'b0, '0);
    checks++; if (ld_req_addr_o !== 32'h103) begin errors++; $display("FAIL lb_req_addr got=%h exp=103", ld_req_addr_o); end
    ld_req_ready_i = 1'b1; cyc(); ld_req_ready_i = 1'b0;
    respond(32'h8000_0000, 1'b0);
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL lb_wb_valid got=%b exp=1", wb_valid_o); end
    checks++; if (wb_data_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_data got=%h exp=ffffff80", wb_data_o); end
    cyc();
    push(32'h103, LSU_LBU, 6'd2, 1'b0, '0);
    ld_req_ready_i = 1'b1; cyc(); ld_req_ready_i = 1'b0;
    respond(32'h8000_0000, 1'b0);
    checks++; if (wb_data_o !== 32'h0000_0080) begin errors++; $display("FAIL lbu_wb_data got=%h exp=00000080", wb_data_o); end
    checks++; if (wb_rob_idx_o !== 6'd2) begin errors++; $display("FAIL lbu_wb_rob got=%0d exp=2", wb_rob_idx_o); end
    cyc();
  endtask

  task automatic test_full_in_order();
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), LSU_LW, 6'(10 + i), 1'b0, '0);
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", req_ready_o); end
    req_valid_i = 1'b1; req_addr_i = 32'h210; req_op_i = LSU_LW; req_rob_idx_i = 6'd14;
    cyc();
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ld_req_addr_o !== 32'h200 + 32'(4 * i)) begin errors++; $display("FAIL full_req_addr%0d got=%h exp=%h", i, ld_req_addr_o, 32'h200 + 32'(4 * i)); end
      ld_req_ready_i = 1'b1; cyc(); ld_req_ready_i = 1'b0;
      respond(32'hD000_0000 + 32'(i), 1'b0);
    end
    cyc();
    checks++; if (wb_rob_idx_o !== 6'd10) begin errors++; $display("FAIL full_hold_rob got=%0d exp=10", wb_rob_idx_o); end
    wb_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 32'h210; req_rob_idx_i = 6'd14;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL full_same_cycle_ready got=%b exp=0", req_ready_o); end
    checks++; if (wb_data_o !== 32'hD000_0000) begin errors++; $display("FAIL full_wb_data0 got=%h exp=d0000000", wb_data_o); end
    cyc();
    req_valid_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++; if (wb_rob_idx_o !== 6'(10 + i)) begin errors++; $display("FAIL full_wb_rob%0d got=%0d exp=%0d", i, wb_rob_idx_o, 10 + i); end
      checks++; if (wb_data_o !== 32'hD000_0000 + 32'(i)) begin errors++; $display("FAIL full_wb_data%0d got=%h exp=%h", i, wb_data_o, 32'hD000_0000 + 32'(i)); end
      cyc();
    end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_misaligned_fwd();
    push(32'h101, LSU_LH, 6'd20, 1'b0, '0);
    checks++; if (ld_req_valid_o !== 1'b0) begin errors++; $display("FAIL mis_no_req got=%b exp=0", ld_req_valid_o); end
    checks++; if (wb_exception_o !== 1'b1) begin errors++; $display("FAIL mis_exc got=%b exp=1", wb_exception_o); end
    checks++; if (wb_ecause_o !== 5'd4) begin errors++; $display("FAIL mis_ecause got=%0d exp=4", wb_ecause_o); end
    checks++; if (wb_rob_idx_o !== 6'd20) begin errors++; $display("FAIL mis_rob got=%0d exp=20", wb_rob_idx_o); end
    cyc();
    push(32'h102, LSU_LH, 6'd21, 1'b1, 32'h1234_5678);
    checks++; if (ld_req_valid_o !== 1'b0) begin errors++; $display("FAIL fwd_no_req got=%b exp=0", ld_req_valid_o); end
    checks++; if (wb_data_o !== 32'h0000_1234) begin errors++; $display("FAIL fwd_data got=%h exp=00001234", wb_data_o); end
    checks++; if (wb_exception_o !== 1'b0) begin errors++; $display("FAIL fwd_exc got=%b exp=0", wb_exception_o); end
    cyc();
  endtask

  task automatic test_skip_order();
    push(32'h300, LSU_LW, 6'd30, 1'b0, '0);
    push(32'h304, LSU_LW, 6'd31, 1'b1, 32'hCAFE_F00D);
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL skip_head_wait got=%b exp=0", wb_valid_o); end
    ld_req_ready_i = 1'b1; cyc(); ld_req_ready_i = 1'b0;
    checks++; if (ld_req_valid_o !== 1'b0) begin errors++; $display("FAIL skip_no_fwd_req got=%b exp=0", ld_req_valid_o); end
    respond(32'h1111_2222, 1'b0);
    checks++; if (wb_rob_idx_o !== 6'd30) begin errors++; $display("FAIL skip_rob0 got=%0d exp=30", wb_rob_idx_o); end
    checks++; if (wb_data_o !== 32'h1111_2222) begin errors++; $display("FAIL skip_data0 got=%h exp=11112222", wb_data_o); end
    cyc();
    checks++; if (wb_rob_idx_o !== 6'd31) begin errors++; $display("FAIL skip_rob1 got=%0d exp=31", wb_rob_idx_o); end
    checks++; if (wb_data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL skip_data1 got=%h exp=cafef00d", wb_data_o); end
    cyc();
  endtask

  task automatic test_flush_drain();
    push(32'h400, LSU_LW, 6'd40, 1'b0, '0);
    push(32'h404, LSU_LW, 6'd41, 1'b0, '0);
    ld_req_ready_i = 1'b1; cyc(); cyc(); ld_req_ready_i = 1'b0;
    flush_i = 1'b1; cyc(); flush_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_wb got=%b exp=0", wb_valid_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", req_ready_o); end
    push(32'h408, LSU_LW, 6'd42, 1'b0, '0);
    checks++; if (ld_req_valid_o !== 1'b0) begin errors++; $display("FAIL drain_hold2 got=%b exp=0", ld_req_valid_o); end
    respond(32'hAAAA_0001, 1'b0);
    checks++; if (ld_req_valid_o !== 1'b0) begin errors++; $display("FAIL drain_hold1 got=%b exp=0", ld_req_valid_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL drain_no_wb got=%b exp=0", wb_valid_o); end
    respond(32'hAAAA_0002, 1'b0);
    checks++; if (ld_req_valid_o !== 1'b1) begin errors++; $display("FAIL drain_release got=%b exp=1", ld_req_valid_o); end
    checks++; if (ld_req_addr_o !== 32'h408) begin errors++; $display("FAIL drain_addr got=%h exp=408", ld_req_addr_o); end
    ld_req_ready_i = 1'b1; cyc(); ld_req_ready_i = 1'b0;
    respond(32'h0000_BEEF, 1'b0);
    checks++; if (wb_rob_idx_o !== 6'd42) begin errors++; $display("FAIL drain_rob got=%0d exp=42", wb_rob_idx_o); end
    checks++; if (wb_data_o !== 32'h0000_BEEF) begin errors++; $display("FAIL drain_data got=%h exp=0000beef", wb_data_o); end
    cyc();
  endtask

  task automatic test_access_fault();
    push(32'h500, LSU_LW, 6'd50, 1'b0, '0);
    ld_req_ready_i = 1'b1; cyc(); ld_req_ready_i = 1'b0;
    respond(32'hFFFF_FFFF, 1'b1);
    checks++; if (wb_exception_o !== 1'b1) begin errors++; $display("FAIL err_exc got=%b exp=1", wb_exception_o); end
    checks++; if (wb_ecause_o !== 5'd5) begin errors++; $display("FAIL err_ecause got=%0d exp=5", wb_ecause_o); end
    checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL err_data got=%h exp=0", wb_data_o); end
    cyc();
    push(32'h504, LSU_LW, 6'd51, 1'b0, '0);
    ld_req_ready_i = 1'b1; cyc(); ld_req_ready_i = 1'b0;
    respond(32'h7654_3210, 1'b0);
    checks++; if (wb_exception_o !== 1'b0) begin errors++; $display("FAIL err_next_exc got=%b exp=0", wb_exception_o); end
    checks++; if (wb_data_o !== 32'h7654_3210) begin errors++; $display("FAIL err_next_data got=%h exp=76543210", wb_data_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    push(32'h600, LSU_LW, 6'd60, 1'b0, '0);
    rst_ni = 1'b0;
    #1;
    checks++; if (ld_req_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_req got=%b exp=0", ld_req_valid_o); end
    cyc();
    rst_ni = 1'b1;
    cyc();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_wb got=%b exp=0", wb_valid_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", req_ready_o); end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_byte_ext();
    test_full_in_order();
    test_misaligned_fwd();
    test_skip_order();
    test_flush_drain();
    test_access_fault();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
